mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Single-port memory arbiter placed between the instruction-fetch unit, the load/store unit and the core's unified memory bus. It grants the shared bus to one requester at a time, sequences each transaction through request and response phases, and raises the `stallreq_from_if`/`stallreq_from_mem` inputs consumed by the pipeline controller. It also drops fetch responses invalidated by a pipeline flush and terminates hung transactions with a timeout error.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TO_W`, 8, timeout counter width; timeout fires at count `2^TO_W-1`
- `clk_i` input 1: core clock
- `n_rst_i` input 1: asynchronous active-low reset
- `flush_i` input 1: pipeline flush from controller
- `if_req_i` input 1: fetch request, held until `if_rvalid_o`
- `if_addr_i` input ADDR_W: fetch address
- `if_rdata_o` output DATA_W: fetch data
- `if_rvalid_o` output 1: fetch response strobe
- `if_err_o` output 1: fetch timeout, valid with `if_rvalid_o`
- `stallreq_from_if_o` output 1: fetch stall request
- `mem_req_i` input 1: load/store request, held until `mem_rvalid_o`
- `mem_we_i` input 1: 1 = store
- `mem_sel_i` input DATA_W/8: byte enables
- `mem_addr_i` input ADDR_W: data address
- `mem_wdata_i` input DATA_W: store data
- `mem_rdata_o` output DATA_W: load data
- `mem_rvalid_o` output 1: load/store response strobe
- `mem_err_o` output 1: data timeout, valid with `mem_rvalid_o`
- `stallreq_from_mem_o` output 1: data stall request
- `bus_req_o` output 1: bus request
- `bus_we_o`, `bus_sel_o`, `bus_addr_o`, `bus_wdata_o` output: registered transaction attributes
- `bus_gnt_i` input 1: bus accepted the request
- `bus_rvalid_i` input 1: bus response valid
- `bus_rdata_i` input DATA_W: bus response data

## Operation
- States:
  - IDLE: no transaction.
  - REQ: `bus_req_o`=1, waiting for `bus_gnt_i`.
  - RESP: waiting for `bus_rvalid_i`.
- IDLE with any request: latch owner and attributes into `bus_*` registers, then go to REQ.
  - Fetch attributes are fixed: `we`=0, `sel`=all ones, `wdata`=0.
  - `flush_i`=1 in IDLE suppresses a fetch launch that cycle; data requests still launch.
- REQ with `bus_gnt_i`: go to RESP. Attributes stay stable for the whole of REQ.
- RESP with `bus_rvalid_i`: go to IDLE.
  - Owner's `rvalid_o` pulses for one cycle.
  - `rdata_o` = `bus_rdata_i`, passed combinationally.
  - The non-owner's `rdata_o` reads 0.
- Flush during a fetch in REQ or RESP:
  - Set a `discard` flag. `bus_req_o` is not withdrawn: the bus protocol requires the request to be held until granted.
  - The response is consumed with no `if_rvalid_o`. `discard` clears on return to IDLE.
- Data transactions are never discarded.
- Stalls (combinational):
  - `stallreq_from_if_o` = `if_req_i & ~if_rvalid_o`
  - `stallreq_from_mem_o` = `mem_req_i & ~mem_rvalid_o`
- Timeout:
  - Counter clears on entry to REQ and increments in REQ and RESP.
  - At `2^TO_W-1`: deassert `bus_req_o`, pulse the owner's `rvalid_o` together with `err_o`, drive `rdata_o` = 0, go to IDLE.
  - A discarded fetch that times out produces no output.
- Simultaneous timeout and `bus_rvalid_i`: the response wins, and `err_o`=0.
- Arbitration in IDLE on simultaneous requests: the data request wins (see Configuration).

## Timing
- Reset values:
  - state = IDLE.
  - All outputs 0 (`bus_*`, `*_rvalid_o`, `*_err_o`, `*_rdata_o`, stall outputs).
  - Internal: `discard`=0, counter=0, last owner = IF.
- Minimum latency with zero-wait bus:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `bus_req_o`=1, `gnt`=1.
  - Cycle 2: `rvalid`, `rvalid_o`=1.
  - Cycle 3: IDLE; the next launch is possible.
- One transaction outstanding; throughput is one transaction per 3 cycles.
- Asynchronous reset mid-transaction returns to IDLE immediately. Any in-flight bus response is ignored.

## Configuration
- `ARB_RR_EN` defined:
  - On simultaneous requests in IDLE, grant the requester not granted last. Last owner updates on each launch.
  - A lone requester is always granted.
- `ARB_RR_EN` undefined: fixed priority, data over fetch. The last-owner register is not implemented.

## Test plan
- Lone fetch, `if_addr_i`=0x100, zero-wait bus returning 0xDEADBEEF:
  - Required: `bus_req_o` at cycle 1; `if_rvalid_o`=1 with `if_rdata_o`=0xDEADBEEF at cycle 2; `stallreq_from_if_o`=1 in cycles 0–1 and 0 in cycle 2.
- Simultaneous fetch and store (`addr` 0x200, `wdata` 0x12345678, `sel` 4'b1111):
  - Required: store granted first with `bus_we_o`=1; fetch is launched in the cycle after `mem_rvalid_o`. The same stimulus repeated with `ARB_RR_EN` grants fetch on the second conflict.
- Fetch in RESP with `flush_i` pulsed and the bus responding 2 cycles later:
  - Required: no `if_rvalid_o`; state returns to IDLE; the next fetch completes normally.
- Load with `bus_gnt_i` held 0 and `TO_W`=4:
  - Required: `bus_req_o` drops after 15 cycles in REQ; `mem_rvalid_o`=1, `mem_err_o`=1, `mem_rdata_o`=0.
- `bus_rvalid_i` arriving in the same cycle the timeout fires:
  - Required: normal response, `err_o`=0.
- `n_rst_i` asserted low in REQ:
  - Required: `bus_req_o`=0 immediately; all outputs at reset values; a later request starts from IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Single-port arbiter: fetch and load/store share one memory bus.
// Define ARB_RR_EN for round-robin on conflicts (default: data over fetch).
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_W   = 8
) (
  input  logic                clk_i,
  input  logic                n_rst_i,
  input  logic                flush_i,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_rvalid_o,
  output logic                if_err_o,
  output logic                stallreq_from_if_o,

  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_rvalid_o,
  output logic                mem_err_o,
  output logic                stallreq_from_mem_o,

  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  state_t            state;
  state_t            state_nx;
  owner_t            owner;
  owner_t            owner_nx;
  logic              discard;
  logic              discard_nx;
  logic [TO_W-1:0]   cnt;
  logic [TO_W-1:0]   cnt_nx;
  logic              we_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx;

  logic fetch_ok;
  logic pick_mem;
  logic launch;
  logic tmo;
  logic resp;
  logic done;
  logic drop;

  assign fetch_ok = if_req_i & ~flush_i;
  assign launch   = (state == IDLE) & (mem_req_i | fetch_ok);

`ifdef ARB_RR_EN
  owner_t last;

  assign pick_mem = mem_req_i &
                    (~fetch_ok | (last == OWN_IF));

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      last <= OWN_IF;
    end else if (launch) begin
      last <= owner_nx;
    end
  end
`else
  assign pick_mem = mem_req_i;
`endif

  assign tmo  = (state != IDLE) & (&cnt);
  assign resp = (state == RESP) & bus_rvalid_i;
  assign done = resp | tmo;

  // A flush in the completing cycle also kills the fetch: its data is stale.
  assign drop = (owner == OWN_IF) & (discard | flush_i);

  assign bus_req_o = (state == REQ) & ~tmo;

  assign if_rvalid_o  = done & (owner == OWN_IF) & ~drop;
  assign mem_rvalid_o = done & (owner == OWN_MEM);

  assign if_err_o  = if_rvalid_o & ~resp;
  assign mem_err_o = mem_rvalid_o & ~resp;

  assign if_rdata_o  = (if_rvalid_o & resp)
                     ? bus_rdata_i : '0;
  assign mem_rdata_o = (mem_rvalid_o & resp)
                     ? bus_rdata_i : '0;

  assign stallreq_from_if_o  = if_req_i & ~if_rvalid_o;
  assign stallreq_from_mem_o = mem_req_i & ~mem_rvalid_o;

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    discard_nx = discard;
    cnt_nx     = cnt;
    we_nx      = bus_we_o;
    sel_nx     = bus_sel_o;
    addr_nx    = bus_addr_o;
    wdata_nx   = bus_wdata_o;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_nx   = REQ;
          cnt_nx     = '0;
          discard_nx = 1'b0;
          if (pick_mem) begin
            owner_nx = OWN_MEM;
            we_nx    = mem_we_i;
            sel_nx   = mem_sel_i;
            addr_nx  = mem_addr_i;
            wdata_nx = mem_wdata_i;
          end else begin
            owner_nx = OWN_IF;
            we_nx    = 1'b0;
            sel_nx   = '1;
            addr_nx  = if_addr_i;
            wdata_nx = '0;
          end
        end
      end
      REQ, RESP: begin
        cnt_nx = cnt + 1'b1;
        // bus_req_o stays up on flush; only the response is dropped.
        if ((owner == OWN_IF) & flush_i) begin
          discard_nx = 1'b1;
        end
        if (done) begin
          state_nx   = IDLE;
          discard_nx = 1'b0;
        end else if ((state == REQ) & bus_gnt_i) begin
          state_nx = RESP;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      discard     <= 1'b0;
      cnt         <= '0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      discard     <= discard_nx;
      cnt         <= cnt_nx;
      bus_we_o    <= we_nx;
      bus_sel_o   <= sel_nx;
      bus_addr_o  <= addr_nx;
      bus_wdata_o <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Random + directed bench for mem_bus_arbiter against a transaction-level model.
// Build with ARB_RR_EN defined to check round-robin arbitration.
module tb_mem_bus_arbiter;

  localparam int TO_W = 4;
  localparam int TMAX = (1 << TO_W) - 1;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_rvalid_o;
  logic        if_err_o;
  logic        stallreq_from_if_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_rvalid_o;
  logic        mem_err_o;
  logic        stallreq_from_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TO_W(TO_W)) dut (
    .clk_i(clk), .n_rst_i(n_rst_i), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .if_err_o(if_err_o), .stallreq_from_if_o(stallreq_from_if_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_rvalid_o(mem_rvalid_o), .mem_err_o(mem_err_o),
    .stallreq_from_mem_o(stallreq_from_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h",
               name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding record with timestamps.
  bit          busy = 0;
  bit          granted = 0;
  bit          dropped = 0;
  bit          own = 0;
  bit          last = 0;
  int          t0 = 0;
  int          cyc = 0;
  logic        a_we = 0;
  logic [3:0]  a_sel = 0;
  logic [31:0] a_addr = 0;
  logic [31:0] a_wdata = 0;
  bit          pv_if_rv = 0;
  bit          pv_mem_rv = 0;

  always begin
    bit expire, resp, done, gone, fok, pm;
    bit e_if_rv, e_mem_rv;
    int age;
    @(negedge clk);
    #2;
    if (!n_rst_i) begin
      busy = 0; granted = 0; dropped = 0; own = 0; last = 0;
      a_we = 0; a_sel = 0; a_addr = 0; a_wdata = 0;
      pv_if_rv = 0; pv_mem_rv = 0;
    end else begin
      age      = cyc - t0 - 1;
      expire   = busy && (age == TMAX);
      resp     = busy && granted && bus_rvalid_i;
      done     = resp || expire;
      gone     = !own && (dropped || flush_i);
      e_if_rv  = done && !own && !gone;
      e_mem_rv = done && own;
      chk("m_bus_req", bus_req_o, busy && !granted && !expire);
      chk("m_bus_we", bus_we_o, a_we);
      chk("m_bus_sel", bus_sel_o, a_sel);
      chk("m_bus_addr", bus_addr_o, a_addr);
      chk("m_bus_wdata", bus_wdata_o, a_wdata);
      chk("m_if_rvalid", if_rvalid_o, e_if_rv);
      chk("m_if_err", if_err_o, e_if_rv && !resp);
      chk("m_if_rdata", if_rdata_o,
          (e_if_rv && resp) ? bus_rdata_i : 32'h0);
      chk("m_mem_rvalid", mem_rvalid_o, e_mem_rv);
      chk("m_mem_err", mem_err_o, e_mem_rv && !resp);
      chk("m_mem_rdata", mem_rdata_o,
          (e_mem_rv && resp) ? bus_rdata_i : 32'h0);
      chk("m_stall_if", stallreq_from_if_o, if_req_i && !e_if_rv);
      chk("m_stall_mem", stallreq_from_mem_o, mem_req_i && !e_mem_rv);
      pv_if_rv  = e_if_rv;
      pv_mem_rv = e_mem_rv;
      if (!busy) begin
        fok = if_req_i && !flush_i;
        if (mem_req_i || fok) begin
          pm = mem_req_i && (!fok || !RR || !last);
          busy = 1; granted = 0; dropped = 0;
          t0 = cyc; own = pm; last = pm;
          a_we    = pm ? mem_we_i : 1'b0;
          a_sel   = pm ? mem_sel_i : 4'hF;
          a_addr  = pm ? mem_addr_i : if_addr_i;
          a_wdata = pm ? mem_wdata_i : 32'h0;
        end
      end else if (done) begin
        busy = 0; dropped = 0;
      end else begin
        if (bus_gnt_i) granted = 1;
        if (!own && flush_i) dropped = 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bus_req"}, bus_req_o, 0);
    chk({tag, "_bus_we"}, bus_we_o, 0);
    chk({tag, "_bus_sel"}, bus_sel_o, 0);
    chk({tag, "_bus_addr"}, bus_addr_o, 0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 0);
    chk({tag, "_rvalids"}, {if_rvalid_o, mem_rvalid_o}, 0);
    chk({tag, "_errs"}, {if_err_o, mem_err_o}, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_mem_rdata"}, mem_rdata_o, 0);
    chk({tag, "_stalls"},
        {stallreq_from_if_o, stallreq_from_mem_o}, 0);
  endtask

  initial begin
    tick(); tick();
    #3 chk_reset_outs("rst0");
    tick();
    n_rst_i = 1'b1;

    // Lone fetch, zero-wait bus
    tick();
    if_req_i = 1; if_addr_i = 32'h100;
    bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF;
    #3 chk("t1_c0_bus_req", bus_req_o, 0);
    chk("t1_c0_stall", stallreq_from_if_o, 1);
    tick();
    #3 chk("t1_c1_bus_req", bus_req_o, 1);
    chk("t1_c1_stall", stallreq_from_if_o, 1);
    chk("t1_c1_addr", bus_addr_o, 32'h100);
    chk("t1_c1_sel", bus_sel_o, 4'hF);
    chk("t1_c1_we", bus_we_o, 0);
    tick();
    #3 chk("t1_c2_rvalid", if_rvalid_o, 1);
    chk("t1_c2_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("t1_c2_stall", stallreq_from_if_o, 0);
    chk("t1_c2_err", if_err_o, 0);
    tick();
    if_req_i = 0;
    #3 chk("t1_c3_rvalid", if_rvalid_o, 0);

    // Fetch/store conflicts
    tick();
    if_req_i = 1; if_addr_i = 32'h300;
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h200;
    mem_wdata_i = 32'h12345678; mem_sel_i = 4'hF;
    bus_rdata_i = 32'h11112222;
    #3 chk("t2_c0_bus_req", bus_req_o, 0);
    tick();
    #3 chk("t2_c1_we", bus_we_o, 1);
    chk("t2_c1_addr", bus_addr_o, 32'h200);
    chk("t2_c1_wdata", bus_wdata_o, 32'h12345678);
    tick();
    #3 chk("t2_c2_mem_rv", mem_rvalid_o, 1);
    chk("t2_c2_if_rv", if_rvalid_o, 0);
    chk("t2_c2_stall_if", stallreq_from_if_o, 1);
    chk("t2_c2_stall_mem", stallreq_from_mem_o, 0);
    tick();
    mem_addr_i = 32'h204; mem_wdata_i = 32'hA5A5A5A5;
    #3 chk("t2_c3_bus_req", bus_req_o, 0);
    tick();
    #3 chk("t2_c4_addr", bus_addr_o, RR ? 32'h300 : 32'h204);
    chk("t2_c4_we", bus_we_o, !RR);
    tick();
    #3 chk("t2_c5_if_rv", if_rvalid_o, RR);
    chk("t2_c5_mem_rv", mem_rvalid_o, !RR);
    tick();
    if_req_i = !RR; mem_req_i = RR;
    #3 chk("t2_c6_bus_req", bus_req_o, 0);
    tick();
    #3 chk("t2_c7_bus_req", bus_req_o, 1);
    tick();
    #3 chk("t2_c8_if_rv", if_rvalid_o, !RR);
    chk("t2_c8_mem_rv", mem_rvalid_o, RR);
    tick();
    if_req_i = 0; mem_req_i = 0;

    // Flush while the fetch waits in RESP
    tick();
    if_req_i = 1; if_addr_i = 32'h400;
    bus_gnt_i = 1; bus_rvalid_i = 0; bus_rdata_i = 32'h55AA55AA;
    tick();
    #3 chk("t3_d1_bus_req", bus_req_o, 1);
    tick();
    flush_i = 1;
    #3 chk("t3_d2_rv", if_rvalid_o, 0);
    tick();
    flush_i = 0;
    #3 chk("t3_d3_stall", stallreq_from_if_o, 1);
    tick();
    bus_rvalid_i = 1;
    #3 chk("t3_d4_rv", if_rvalid_o, 0);
    chk("t3_d4_rdata", if_rdata_o, 0);
    tick();
    #3 chk("t3_d5_bus_req", bus_req_o, 0);
    tick();
    #3 chk("t3_d6_bus_req", bus_req_o, 1);
    tick();
    #3 chk("t3_d7_rv", if_rvalid_o, 1);
    chk("t3_d7_rdata", if_rdata_o, 32'h55AA55AA);
    tick();
    if_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;

    // Load timing out in REQ
    tick();
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h500;
    bus_rdata_i = 32'hFFFFFFFF;
    for (int i = 1; i <= TMAX; i++) begin
      tick();
      #3 chk("t4_req_held", bus_req_o, 1);
    end
    tick();
    #3 chk("t4_bus_req", bus_req_o, 0);
    chk("t4_rv", mem_rvalid_o, 1);
    chk("t4_err", mem_err_o, 1);
    chk("t4_rdata", mem_rdata_o, 0);
    tick();
    mem_req_i = 0;
    #3 chk("t4_after", mem_rvalid_o, 0);

    // Response in the same cycle as timeout
    tick();
    mem_req_i = 1; mem_addr_i = 32'h600;
    tick();
    bus_gnt_i = 1;
    #3 chk("t5_bus_req", bus_req_o, 1);
    for (int i = 2; i < TMAX + 1; i++) begin
      tick();
      bus_gnt_i = 0;
    end
    #3 chk("t5_no_rv_yet", mem_rvalid_o, 0);
    tick();
    bus_rvalid_i = 1; bus_rdata_i = 32'hCAFEF00D;
    #3 chk("t5_rv", mem_rvalid_o, 1);
    chk("t5_err", mem_err_o, 0);
    chk("t5_rdata", mem_rdata_o, 32'hCAFEF00D);
    tick();
    mem_req_i = 0; bus_rvalid_i = 0;

    // Asynchronous reset in REQ
    tick();
    if_req_i = 1; if_addr_i = 32'h700;
    tick();
    #3 chk("t6_bus_req", bus_req_o, 1);
    tick();
    n_rst_i = 0; if_req_i = 0; bus_gnt_i = 1; bus_rvalid_i = 1;
    #1 chk_reset_outs("t6_rst");
    tick();
    tick();
    n_rst_i = 1; if_req_i = 1; if_addr_i = 32'h704;
    bus_rdata_i = 32'h0BADF00D;
    #3 chk("t6_r0_bus_req", bus_req_o, 0);
    tick();
    #3 chk("t6_r1_bus_req", bus_req_o, 1);
    chk("t6_r1_addr", bus_addr_o, 32'h704);
    tick();
    #3 chk("t6_r2_rv", if_rvalid_o, 1);
    chk("t6_r2_rdata", if_rdata_o, 32'h0BADF00D);
    tick();
    if_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      int mode;
      tick();
      mode = (k / 64) % 4;
      if (if_req_i && pv_if_rv) if_req_i = 0;
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i  = 1;
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (mem_req_i && pv_mem_rv) mem_req_i = 0;
      if (!mem_req_i && $urandom_range(0, 2) == 0) begin
        mem_req_i   = 1;
        mem_we_i    = $urandom_range(0, 1);
        mem_sel_i   = $urandom_range(0, 15);
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
      end
      flush_i     = ($urandom_range(0, 7) == 0);
      bus_rdata_i = $urandom;
      if (mode == 3) begin
        bus_gnt_i    = 0;
        bus_rvalid_i = 0;
      end else if (mode == 2) begin
        bus_gnt_i    = ($urandom_range(0, 9) == 0);
        bus_rvalid_i = ($urandom_range(0, 9) == 0);
      end else begin
        bus_gnt_i    = ($urandom_range(0, 2) == 0);
        bus_rvalid_i = ($urandom_range(0, 2) == 0);
      end
    end
    tick();
    #4;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
